// File: rtl/address_deserializer.sv
// Reads the 16-bit host address out of two LV165A shift registers and
// unscrambles it into one atomically updated word with a done pulse.
module address_deserializer #(
  parameter int LOAD_CYCLES = 2,
  parameter int CLK_DIV     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_cancel,
  input  logic        i_adrin1,
  input  logic        i_adrin2,
  output logic        o_shld,
  output logic        o_serclk,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_address,
  output logic [3:0]  o_count
);

  typedef enum logic [2:0] {IDLE, LOAD, LOW, SAMPLE, HIGH, DONE} state_t;

  localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYCLES - 1);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);

  state_t      state, state_d;
  logic [15:0] phase_cnt, phase_cnt_d;
  logic [3:0]  bit_cnt, bit_cnt_d;
  logic [15:0] shadow, shadow_d;
  logic [15:0] address_d;

  // Board scramble: output bit that receives adrin1 / adrin2 at sample index n.
  function automatic logic [3:0] pos1(input logic [2:0] n);
    case (n)
      3'd0:    pos1 = 4'd6;
      3'd1:    pos1 = 4'd13;
      3'd2:    pos1 = 4'd9;
      3'd3:    pos1 = 4'd14;
      3'd4:    pos1 = 4'd15;
      3'd5:    pos1 = 4'd0;
      3'd6:    pos1 = 4'd8;
      default: pos1 = 4'd7;
    endcase
  endfunction

  function automatic logic [3:0] pos2(input logic [2:0] n);
    case (n)
      3'd0:    pos2 = 4'd10;
      3'd1:    pos2 = 4'd11;
      3'd2:    pos2 = 4'd3;
      3'd3:    pos2 = 4'd1;
      3'd4:    pos2 = 4'd2;
      3'd5:    pos2 = 4'd12;
      3'd6:    pos2 = 4'd4;
      default: pos2 = 4'd5;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shadow    <= '0;
      o_address <= '0;
    end else begin
      state     <= state_d;
      phase_cnt <= phase_cnt_d;
      bit_cnt   <= bit_cnt_d;
      shadow    <= shadow_d;
      o_address <= address_d;
    end
  end

  always_comb begin
    state_d     = state;
    phase_cnt_d = phase_cnt;
    bit_cnt_d   = bit_cnt;
    shadow_d    = shadow;
    address_d   = o_address;
    o_shld      = 1'b1;
    o_serclk    = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;

    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_d     = LOAD;
          phase_cnt_d = '0;
        end
      end
      LOAD: begin
        o_shld = 1'b0;
        if (phase_cnt == LOAD_LAST) begin
          state_d     = LOW;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt + 16'd1;
        end
      end
      LOW: begin
        if (phase_cnt == DIV_LAST) begin
          state_d     = SAMPLE;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt + 16'd1;
        end
      end
      SAMPLE: begin
        shadow_d[pos1(bit_cnt[2:0])] = i_adrin1;
        shadow_d[pos2(bit_cnt[2:0])] = i_adrin2;
        bit_cnt_d = bit_cnt + 4'd1;
        // The final bit goes straight into the published word, so no partial value is ever seen.
        if (bit_cnt == 4'd7) begin
          state_d   = DONE;
          address_d = shadow_d;
        end else begin
          state_d     = HIGH;
          phase_cnt_d = '0;
        end
      end
      HIGH: begin
        o_serclk = 1'b1;
        if (phase_cnt == DIV_LAST) begin
          state_d     = LOW;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt + 16'd1;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // DONE is left out: by then the word is already published.
    if (i_cancel && state != IDLE && state != DONE) begin
      state_d     = IDLE;
      phase_cnt_d = '0;
      bit_cnt_d   = '0;
      shadow_d    = shadow;
      address_d   = o_address;
    end
  end

  assign o_count = bit_cnt;

endmodule

// File: tb/tb_address_deserializer.sv
// Directed bench for address_deserializer: two LV165A models per DUT,
// one DUT at default timing and one with CLK_DIV=3, LOAD_CYCLES=1.
`timescale 1ns/1ps
module tb_address_deserializer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, cancel = 1'b0, start3 = 1'b0, cancel3 = 1'b0;
  logic adrin1, adrin2, adrin1b, adrin2b;
  logic shld, serclk, busy, done, shld3, serclk3, busy3, done3;
  logic [15:0] address, address3;
  logic [3:0]  count, count3;
  logic [7:0]  par1 = '0, par2 = '0, par1b = '0, par2b = '0;
  logic [7:0]  sr1 = '0, sr2 = '0, sr1b = '0, sr2b = '0;
  int vectors = 0, miscompares = 0;
  int edge_cnt = 0, low_cnt = 0;

  always #5 clk = ~clk;

  address_deserializer dut (
    .clk(clk), .reset(reset), .i_start(start), .i_cancel(cancel),
    .i_adrin1(adrin1), .i_adrin2(adrin2), .o_shld(shld), .o_serclk(serclk),
    .o_busy(busy), .o_done(done), .o_address(address), .o_count(count));

  address_deserializer #(.LOAD_CYCLES(1), .CLK_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .i_start(start3), .i_cancel(cancel3),
    .i_adrin1(adrin1b), .i_adrin2(adrin2b), .o_shld(shld3), .o_serclk(serclk3),
    .o_busy(busy3), .o_done(done3), .o_address(address3), .o_count(count3));

  // LV165A: asynchronous parallel load while SH/LD* low, shift toward Q_H on serclk rise.
  always @(posedge serclk or negedge shld)
    if (!shld) begin sr1 <= par1; sr2 <= par2; end
    else begin sr1 <= {sr1[6:0], 1'b0}; sr2 <= {sr2[6:0], 1'b0}; end

  always @(posedge serclk3 or negedge shld3)
    if (!shld3) begin sr1b <= par1b; sr2b <= par2b; end
    else begin sr1b <= {sr1b[6:0], 1'b0}; sr2b <= {sr2b[6:0], 1'b0}; end

  assign adrin1  = sr1[7];
  assign adrin2  = sr2[7];
  assign adrin1b = sr1b[7];
  assign adrin2b = sr2b[7];

  always @(posedge serclk) edge_cnt <= edge_cnt + 1;
  always @(posedge clk) if (!shld) low_cnt <= low_cnt + 1;

  // Parallel-load pattern {reg1, reg2} that presents address a with the board wiring.
  function automatic logic [15:0] scramble(input logic [15:0] a);
    int m1[8];
    int m2[8];
    logic [7:0] p1, p2;
    m1 = '{9, 2, 6, 1, 0, 15, 7, 8};
    m2 = '{5, 4, 12, 14, 13, 3, 11, 10};
    for (int n = 0; n < 8; n++) begin
      p1[7-n] = a[15-m1[n]];
      p2[7-n] = a[15-m2[n]];
    end
    return {p1, p2};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts one acquisition on the default DUT; lat = edges from start sample to o_done, 0 on timeout.
  task automatic run_acq(input logic [15:0] a, input logic with_cancel, output int lat);
    {par1, par2} = scramble(a);
    start = 1'b1;
    cancel = with_cancel;
    tick();
    start = 1'b0;
    cancel = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200 && lat == 0; i++) begin
      tick();
      if (done) lat = i;
    end
  endtask

  task automatic test_reset;
    #12;
    vectors++; if (shld !== 1'b1) begin miscompares++; $display("FAIL reset_shld: got %b want 1", shld); end
    vectors++; if (serclk !== 1'b0) begin miscompares++; $display("FAIL reset_serclk: got %b want 0", serclk); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (address !== 16'h0000) begin miscompares++; $display("FAIL reset_address: got %h want 0000", address); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int lat, e0, l0;
    e0 = edge_cnt;
    l0 = low_cnt;
    run_acq(16'hA002, 1'b0, lat);
    vectors++; if (lat !== 25) begin miscompares++; $display("FAIL basic_latency: got %0d want 25", lat); end
    vectors++; if (address !== 16'hA002) begin miscompares++; $display("FAIL basic_address: got %h want a002", address); end
    vectors++; if (edge_cnt - e0 !== 7) begin miscompares++; $display("FAIL basic_serclk_edges: got %0d want 7", edge_cnt - e0); end
    vectors++; if (low_cnt - l0 !== 2) begin miscompares++; $display("FAIL basic_shld_low: got %0d want 2", low_cnt - l0); end
    tick();
  endtask

  task automatic test_cancel;
    int lat, e0, nd;
    bit reached;
    {par1, par2} = scramble(16'h1234);
    e0 = edge_cnt;
    reached = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      tick();
      if (edge_cnt - e0 == 3) reached = 1;
    end
    vectors++; if (reached !== 1'b1) begin miscompares++; $display("FAIL cancel_third_edge: got %0d edges want 3", edge_cnt - e0); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cancel_busy: got %b want 0", busy); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL cancel_count: got %0d want 0", count); end
    vectors++; if ({shld, serclk} !== 2'b10) begin miscompares++; $display("FAIL cancel_shld_serclk: got %b want 10", {shld, serclk}); end
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) nd++;
    end
    vectors++; if (nd !== 0) begin miscompares++; $display("FAIL cancel_no_done: got %0d pulses want 0", nd); end
    vectors++; if (address !== 16'hA002) begin miscompares++; $display("FAIL cancel_address_kept: got %h want a002", address); end
    // start together with cancel while idle must still launch an acquisition
    run_acq(16'h1234, 1'b1, lat);
    vectors++; if (lat !== 25) begin miscompares++; $display("FAIL cancel_restart_latency: got %0d want 25", lat); end
    vectors++; if (address !== 16'h1234) begin miscompares++; $display("FAIL cancel_restart_address: got %h want 1234", address); end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat, gap;
    run_acq(16'hFFFF, 1'b0, lat);
    vectors++; if (address !== 16'hFFFF) begin miscompares++; $display("FAIL b2b_first_address: got %h want ffff", address); end
    {par1, par2} = scramble(16'h0001);
    start = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_start_in_done: got busy %b want 0", busy); end
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
    gap = 0;
    for (int i = 1; i <= 200 && gap == 0; i++) begin
      tick();
      if (done) gap = i + 2;
    end
    // one edge leaving DONE, one sampling start in IDLE, then the 25-cycle acquisition
    vectors++; if (gap !== 27) begin miscompares++; $display("FAIL b2b_gap: got %0d want 27", gap); end
    vectors++; if (address !== 16'h0001) begin miscompares++; $display("FAIL b2b_second_address: got %h want 0001", address); end
    tick();
  endtask

  task automatic test_clk_div;
    int lat, rises, last_rise, bad_hi, bad_period;
    logic prev;
    {par1b, par2b} = scramble(16'h6040);
    lat = 0; rises = 0; last_rise = 0; bad_hi = 0; bad_period = 0; prev = 1'b0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 1; i <= 200 && lat == 0; i++) begin
      tick();
      if (serclk3 && !prev) begin
        if (last_rise != 0 && i - last_rise != 7) bad_period++;
        last_rise = i;
        rises++;
      end
      if (!serclk3 && prev && i - last_rise != 3) bad_hi++;
      prev = serclk3;
      if (done3) lat = i;
    end
    vectors++; if (lat !== 54) begin miscompares++; $display("FAIL div3_latency: got %0d want 54", lat); end
    vectors++; if (address3 !== 16'h6040) begin miscompares++; $display("FAIL div3_address: got %h want 6040", address3); end
    vectors++; if (rises !== 7) begin miscompares++; $display("FAIL div3_serclk_edges: got %0d want 7", rises); end
    vectors++; if (bad_hi !== 0) begin miscompares++; $display("FAIL div3_high_phase: got %0d bad phases want 0", bad_hi); end
    vectors++; if (bad_period !== 0) begin miscompares++; $display("FAIL div3_period: got %0d bad periods want 0", bad_period); end
    tick();
  endtask

  task automatic test_hold_start;
    int lat, nd, cnt10;
    {par1, par2} = scramble(16'h00FF);
    nd = 0; lat = 0;
    start = 1'b1;
    tick();
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (done) begin
        nd++;
        if (lat == 0) lat = i;
      end
    end
    start = 1'b0;
    tick();
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL hold_done_count: got %0d want 1", nd); end
    vectors++; if (lat !== 25) begin miscompares++; $display("FAIL hold_latency: got %0d want 25", lat); end
    vectors++; if (address !== 16'h00FF) begin miscompares++; $display("FAIL hold_address: got %h want 00ff", address); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_idle_after: got busy %b want 0", busy); end
    {par1, par2} = scramble(16'h5A3C);
    lat = 0; cnt10 = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 200 && lat == 0; i++) begin
      if (i == 8) start = 1'b1;
      if (i == 9) start = 1'b0;
      tick();
      if (i == 10) cnt10 = int'(count);
      if (done) lat = i;
    end
    vectors++; if (cnt10 !== 3) begin miscompares++; $display("FAIL pulse_count: got %0d want 3", cnt10); end
    vectors++; if (lat !== 25) begin miscompares++; $display("FAIL pulse_latency: got %0d want 25", lat); end
    vectors++; if (address !== 16'h5A3C) begin miscompares++; $display("FAIL pulse_address: got %h want 5a3c", address); end
    tick();
  endtask

  task automatic test_reset_mid;
    {par1, par2} = scramble(16'hFFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    vectors++; if (count !== 4'd4) begin miscompares++; $display("FAIL midreset_pre_count: got %0d want 4", count); end
    reset = 1'b0;
    #1;
    vectors++; if (shld !== 1'b1) begin miscompares++; $display("FAIL midreset_shld: got %b want 1", shld); end
    vectors++; if (serclk !== 1'b0) begin miscompares++; $display("FAIL midreset_serclk: got %b want 0", serclk); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
    vectors++; if (address !== 16'h0000) begin miscompares++; $display("FAIL midreset_address: got %h want 0000", address); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL midreset_count: got %0d want 0", count); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_after_release: got busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cancel();
    test_back_to_back();
    test_clk_div();
    test_hold_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
